fir_transpose_param: RTL and testbench

- Parametrised transposed-form FIR filter: TAPS coefficients, configurable sample/coefficient/output widths.
- Adds over the fixed 6-tap generation:
  - valid-qualified sample stream with stall support
  - double-buffered, runtime-loadable coefficient bank with glitch-free swap
  - output rounding shift, optional saturation
  - synchronous clear
- Sits between the sample source (ADC/decimator) and downstream DSP, same clock domain.

---
 rtl/fir_transpose_param.sv | 87 ++++++++
 tb/tb_fir_transpose_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_transpose_param.sv
// fir_transpose_param: transposed-form FIR with valid/stall, double-buffered coefficients, rounding shift and optional saturation
module fir_transpose_param #(
  parameter int DW    = 16,
  parameter int CW    = 14,
  parameter int TAPS  = 6,
  parameter int OW    = 26,
  parameter int SHIFT = 0,
  parameter int SAT   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [DW-1:0]             in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [CW-1:0]             coef_data,
  input  logic                      coef_swap,
  output logic                      out_valid,
  output logic [OW-1:0]             out_data,
  output logic                      out_sat
);
  localparam int AW = DW + CW + $clog2(TAPS);
  localparam int RW = AW + 1;
  localparam logic [RW-1:0] HALF = (RW'(1) << SHIFT) >> 1;
  localparam logic [OW-1:0] MAXO = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MINO = {1'b1, {(OW-1){1'b0}}};

  logic signed [DW-1:0] x_q;
  logic                 valid_q;
  logic signed [CW-1:0] ca [TAPS];
  logic signed [CW-1:0] sh [TAPS];
  logic signed [AW-1:0] p [TAPS];
  logic signed [AW-1:0] s [1:TAPS-1];
  logic signed [AW-1:0] acc;
  logic signed [RW-1:0] r;
  logic                 ovf;
  logic                 sat_n;
  logic [OW-1:0]        dn;

  // per-tap products of the current sample, sign-extended to the accumulator width
  always_comb
    for (int k = 0; k < TAPS; k++) p[k] = AW'(x_q) * AW'(ca[k]);

  // final sum, round-half-up shift, then clamp or wrap to the output width
  always_comb begin
    acc   = p[0] + s[1];
    r     = $signed(RW'(acc) + HALF) >>> SHIFT;
    ovf   = r != {{(RW-OW){r[OW-1]}}, r[OW-1:0]};
    sat_n = (SAT != 0) && ovf;
    dn    = sat_n ? (r[RW-1] ? MINO : MAXO) : r[OW-1:0];
  end

  // shadow bank takes writes; swap copies the pre-write shadow into the active bank
  always_ff @(posedge clk)
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        ca[k] <= '0;
        sh[k] <= '0;
      end
    end else begin
      if (coef_swap)
        for (int k = 0; k < TAPS; k++) ca[k] <= sh[k];
      if (coef_we && int'(coef_addr) < TAPS) sh[coef_addr] <= coef_data;
    end

  // sample register and partial-sum chain; chain and outputs advance only on valid samples
  always_ff @(posedge clk)
    if (!reset || clear) begin
      if (!reset) x_q <= '0;
      valid_q   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      for (int k = 1; k < TAPS; k++) s[k] <= '0;
    end else begin
      if (in_valid) x_q <= in_data;
      valid_q   <= in_valid;
      out_valid <= valid_q;
      if (valid_q) begin
        s[TAPS-1] <= p[TAPS-1];
        for (int k = 1; k < TAPS-1; k++) s[k] <= p[k] + s[k+1];
        out_data <= dn;
        out_sat  <= sat_n;
      end
    end
endmodule

// File: tb/tb_fir_transpose_param.sv
// tb_fir_transpose_param: directed checks of the transposed FIR against a direct-convolution model
module tb_fir_transpose_param;
  logic clk = 1'b0;
  logic reset = 1'b0, clear = 1'b0, in_valid = 1'b0, coef_we = 1'b0, coef_swap = 1'b0;
  logic [15:0] in_data = '0;
  logic [2:0]  coef_addr = '0;
  logic [13:0] coef_data = '0;
  logic va, vw, vr, sa, sw, sr;
  logic [25:0] da, dw, dr;
  int total = 0, bad = 0;

  typedef struct { longint a, w, r; bit sa, sw; } rec_t;
  rec_t q[$];

  longint act [6], shd [6], hx [6], hb [6][6], mx = 0;
  bit mvq = 0, ev = 0;
  logic [25:0] ea = '0, ew = '0, er = '0;
  logic esa = 1'b0, esw = 1'b0, esr = 1'b0;

  always #5 clk = ~clk;

  fir_transpose_param dut_a (.clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
    .out_valid(va), .out_data(da), .out_sat(sa));
  fir_transpose_param #(.SAT(0)) dut_w (.clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
    .out_valid(vw), .out_data(dw), .out_sat(sw));
  fir_transpose_param #(.SHIFT(2)) dut_r (.clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
    .out_valid(vr), .out_data(dr), .out_sat(sr));

  function automatic void chk(string nm, longint act_v, longint exp_v);
    total++;
    if (act_v != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act_v, exp_v);
    end
  endfunction

  function automatic void fmt(input longint acc, input int shf, input bit sat, output logic [25:0] d, output logic s);
    longint r, lo, hi;
    r  = shf > 0 ? (acc + (longint'(1) <<< (shf - 1))) >>> shf : acc;
    lo = -(longint'(1) <<< 25);
    hi = (longint'(1) <<< 25) - 1;
    s  = 1'b0;
    if (sat && r > hi) begin d = 26'(hi); s = 1'b1; end
    else if (sat && r < lo) begin d = 26'(lo); s = 1'b1; end
    else d = 26'(r);
  endfunction

  // sample-level model: each output is the sum over the last six samples of x times the bank in force when it was taken
  task automatic step(input bit rs, cl, iv, input logic [15:0] id, input bit we, input logic [2:0] ad,
                      input logic [13:0] cd, input bit sp);
    longint acc;
    if (!rs) begin
      for (int k = 0; k < 6; k++) begin act[k] = 0; shd[k] = 0; hx[k] = 0; end
      mvq = 0; mx = 0; ev = 0;
      ea = '0; ew = '0; er = '0; esa = 1'b0; esw = 1'b0; esr = 1'b0;
    end else begin
      if (cl) begin
        for (int k = 0; k < 6; k++) hx[k] = 0;
        mvq = 0; ev = 0;
        ea = '0; ew = '0; er = '0; esa = 1'b0; esw = 1'b0; esr = 1'b0;
      end else begin
        ev = mvq;
        if (mvq) begin
          for (int k = 5; k > 0; k--) begin hx[k] = hx[k-1]; hb[k] = hb[k-1]; end
          hx[0] = mx;
          hb[0] = act;
          acc = 0;
          for (int k = 0; k < 6; k++) acc += hb[k][k] * hx[k];
          fmt(acc, 0, 1'b1, ea, esa);
          fmt(acc, 0, 1'b0, ew, esw);
          fmt(acc, 2, 1'b1, er, esr);
        end
        mvq = iv;
        if (iv) mx = longint'($signed(id));
      end
      if (sp) act = shd;
      if (we && ad < 6) shd[ad] = longint'($signed(cd));
    end
  endtask

  // every cycle: advance the model with the inputs seen at the edge, compare all three instances
  initial begin
    bit b_rs, b_cl, b_iv, b_we, b_sp;
    logic [15:0] b_id;
    logic [2:0]  b_ad;
    logic [13:0] b_cd;
    rec_t rr;
    forever begin
      @(posedge clk);
      b_rs = reset; b_cl = clear; b_iv = in_valid; b_id = in_data;
      b_we = coef_we; b_ad = coef_addr; b_cd = coef_data; b_sp = coef_swap;
      #1;
      step(b_rs, b_cl, b_iv, b_id, b_we, b_ad, b_cd, b_sp);
      chk("valid_a", va, ev);
      chk("valid_w", vw, ev);
      chk("valid_r", vr, ev);
      chk("data_a", $signed(da), $signed(ea));
      chk("data_w", $signed(dw), $signed(ew));
      chk("data_r", $signed(dr), $signed(er));
      chk("sat_a", sa, esa);
      chk("sat_w", sw, esw);
      chk("sat_r", sr, esr);
      if (va) begin
        rr.a = $signed(da); rr.w = $signed(dw); rr.r = $signed(dr); rr.sa = sa; rr.sw = sw;
        q.push_back(rr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input longint c[6], input bit sp);
    for (int k = 0; k < 6; k++) begin
      coef_we = 1'b1; coef_addr = 3'(k); coef_data = 14'(c[k]);
      cyc();
    end
    coef_we = 1'b0; coef_swap = sp;
    cyc();
    coef_swap = 1'b0;
  endtask

  task automatic feed(input longint x, input int gap);
    in_valid = 1'b1; in_data = 16'(x);
    cyc();
    in_valid = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic expq(string nm, int sel, longint e[$]);
    chk({nm, "_count"}, q.size(), e.size());
    for (int i = 0; i < e.size() && i < q.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), sel == 0 ? q[i].a : sel == 1 ? q[i].w : q[i].r, e[i]);
  endtask

  // directed stimulus with hand-computed expectations
  initial begin
    longint c[6];
    longint e[$];
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    chk("rst_valid", va, 0);
    chk("rst_data", $signed(da), 0);
    chk("rst_sat", sa, 0);

    c = '{1, 2, 3, 4, 5, 6};
    load(c, 1'b1);
    q.delete();
    in_valid = 1'b1; in_data = 16'd1;
    cyc();
    in_data = 16'd0;
    chk("lat_cycle1", va, 0);
    cyc();
    chk("lat_cycle2", va, 1);
    chk("lat_first_data", $signed(da), 1);
    repeat (5) cyc();
    drain();
    e = '{1, 2, 3, 4, 5, 6, 0};
    expq("impulse", 0, e);
    for (int i = 0; i < q.size(); i++) chk($sformatf("impulse_sat[%0d]", i), q[i].sa, 0);

    q.delete();
    for (int i = 0; i < 7; i++) feed(i == 0 ? 1 : 0, 2);
    drain();
    expq("stall", 0, e);

    q.delete();
    feed(1, 0); feed(0, 0); feed(0, 0);
    cyc(); cyc();
    clear = 1'b1; in_valid = 1'b1; in_data = 16'd5;
    cyc();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_valid", va, 0);
    chk("clr_data", $signed(da), 0);
    for (int i = 0; i < 3; i++) feed(0, 0);
    for (int i = 0; i < 6; i++) feed(i == 0 ? 1 : 0, 0);
    drain();
    e = '{1, 2, 3, 0, 0, 0, 1, 2, 3, 4, 5, 6};
    expq("clear", 0, e);

    c = '{-8192, -8192, -8192, -8192, -8192, -8192};
    load(c, 1'b1);
    q.delete();
    for (int i = 0; i < 6; i++) feed(-32768, 0);
    drain();
    e = '{33554431, 33554431, 33554431, 33554431, 33554431, 33554431};
    expq("sat_clamp", 0, e);
    e = '{0, 0, 0, 0, 0, 0};
    expq("sat_wrap", 1, e);
    if (q.size() == 6) begin
      chk("sat_flag_clamp", q[5].sa, 1);
      chk("sat_flag_wrap", q[5].sw, 0);
    end
    pulse_clear();

    c = '{1, 0, 0, 0, 0, 0};
    load(c, 1'b1);
    q.delete();
    feed(6, 1); feed(-6, 1); feed(5, 1);
    drain();
    e = '{2, -1, 1};
    expq("round_sh2", 2, e);
    e = '{6, -6, 5};
    expq("round_sh0", 0, e);

    c = '{1, 1, 1, 1, 1, 1};
    load(c, 1'b1);
    c = '{2, 2, 2, 2, 2, 2};
    load(c, 1'b0);
    coef_we = 1'b1; coef_addr = 3'd6; coef_data = 14'd100;
    cyc();
    coef_addr = 3'd7;
    cyc();
    coef_we = 1'b0;
    q.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 16'd1;
      coef_swap = (i == 8); coef_we = (i == 8); coef_addr = 3'd0; coef_data = 14'd3;
      cyc();
    end
    coef_swap = 1'b0; coef_we = 1'b0;
    drain();
    e = '{1, 2, 3, 4, 5, 6, 6, 6, 7, 8, 9, 10, 11, 12, 12, 12};
    expq("swap", 0, e);
    pulse_clear();
    coef_swap = 1'b1;
    cyc();
    coef_swap = 1'b0;
    q.delete();
    for (int i = 0; i < 6; i++) feed(i == 0 ? 1 : 0, 0);
    drain();
    e = '{3, 2, 2, 2, 2, 2};
    expq("write_during_swap", 0, e);

    feed(1, 0);
    in_valid = 1'b1; in_data = 16'd0; reset = 1'b0;
    cyc();
    reset = 1'b1; in_valid = 1'b0;
    chk("rst_mid_valid", va, 0);
    chk("rst_mid_data", $signed(da), 0);
    q.delete();
    for (int i = 0; i < 6; i++) feed(i == 0 ? 1 : 0, 0);
    drain();
    e = '{0, 0, 0, 0, 0, 0};
    expq("after_reset", 0, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
